// File: rtl/arb_txn_mux.sv
// arb_txn_mux: steers arbiter-granted manager requests into a
// registered skid buffer and routes in-order responses back.
module arb_txn_mux #(
  parameter int NUM_M   = 2,
  parameter int A_WIDTH = 20,
  parameter int D_WIDTH = 16,
  localparam int G_BITS = $clog2(NUM_M + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_M-1:0]         m_req_valid,
  output logic [NUM_M-1:0]         m_req_ready,
  input  logic [NUM_M-1:0]         m_req_we,
  input  logic [NUM_M*A_WIDTH-1:0] m_req_addr,
  input  logic [NUM_M*D_WIDTH-1:0] m_req_wdata,
  output logic [NUM_M-1:0]         m_resp_valid,
  input  logic [NUM_M-1:0]         m_resp_ready,
  output logic [D_WIDTH-1:0]       m_resp_rdata,
  output logic [NUM_M-1:0]         g_want,
  input  logic [G_BITS-1:0]        g_req,
  input  logic [G_BITS-1:0]        g_resp,
  output logic                     req_accepted,
  output logic                     resp_accepted,
  output logic                     s_req_valid,
  output logic                     s_req_we,
  output logic [A_WIDTH-1:0]       s_req_addr,
  output logic [D_WIDTH-1:0]       s_req_wdata,
  input  logic                     s_req_ready,
  input  logic                     s_resp_valid,
  input  logic [D_WIDTH-1:0]       s_resp_rdata,
  output logic                     s_resp_ready
);

  typedef struct packed {
    logic               we;
    logic [A_WIDTH-1:0] addr;
    logic [D_WIDTH-1:0] wdata;
  } pl_t;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } st_t;

  st_t  state_q, state_d;
  pl_t  out_q, out_d;
  pl_t  skid_q, skid_d;
  pl_t  in_pl;
  logic out_valid;
  logic skid_valid;
  logic in_ready;
  logic sel_valid;
  logic accept;
  logic drain;

  assign out_valid  = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);
  assign in_ready   = !skid_valid;
  assign g_want     = m_req_valid;

  // Select the granted manager; out-of-range grants match nothing.
  always_comb begin
    m_req_ready = '0;
    sel_valid   = 1'b0;
    in_pl       = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (g_req == G_BITS'(i)) begin
        m_req_ready[i] = in_ready;
        sel_valid      = m_req_valid[i];
        in_pl.we       = m_req_we[i];
        in_pl.addr     = m_req_addr[i*A_WIDTH +: A_WIDTH];
        in_pl.wdata    = m_req_wdata[i*D_WIDTH +: D_WIDTH];
      end
    end
  end

  assign accept       = sel_valid && in_ready;
  assign req_accepted = accept;
  assign drain        = out_valid && s_req_ready;

  // Skid buffer next state: accept loads out (or skid when stalled).
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = in_pl;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && drain) begin
          out_d = in_pl;
        end else if (accept) begin
          skid_d  = in_pl;
          state_d = FULL;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          out_d   = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Register state and payloads; reset discards buffered requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign s_req_valid = out_valid;
  assign s_req_we    = out_q.we;
  assign s_req_addr  = out_q.addr;
  assign s_req_wdata = out_q.wdata;

  // Route the response to the response-granted manager only.
  always_comb begin
    m_resp_valid = '0;
    s_resp_ready = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (g_resp == G_BITS'(i)) begin
        m_resp_valid[i] = s_resp_valid;
        s_resp_ready    = m_resp_ready[i];
      end
    end
  end

  assign resp_accepted = s_resp_valid && s_resp_ready;
  assign m_resp_rdata  = s_resp_rdata;

endmodule

// File: tb/tb_arb_txn_mux.sv
// tb_arb_txn_mux: directed stimulus with queue-based scoreboard
// for subordinate requests and manager responses.
module tb_arb_txn_mux;

  localparam int NUM_M  = 2;
  localparam int AW     = 20;
  localparam int DW     = 16;
  localparam int GB     = 2;
  localparam int PW     = 1 + AW + DW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_M-1:0]  m_req_valid;
  logic [NUM_M-1:0]  m_req_ready;
  logic [NUM_M-1:0]  m_req_we;
  logic [NUM_M*AW-1:0] m_req_addr;
  logic [NUM_M*DW-1:0] m_req_wdata;
  logic [NUM_M-1:0]  m_resp_valid;
  logic [NUM_M-1:0]  m_resp_ready;
  logic [DW-1:0]     m_resp_rdata;
  logic [NUM_M-1:0]  g_want;
  logic [GB-1:0]     g_req;
  logic [GB-1:0]     g_resp;
  logic              req_accepted;
  logic              resp_accepted;
  logic              s_req_valid;
  logic              s_req_we;
  logic [AW-1:0]     s_req_addr;
  logic [DW-1:0]     s_req_wdata;
  logic              s_req_ready;
  logic              s_resp_valid;
  logic [DW-1:0]     s_resp_rdata;
  logic              s_resp_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [PW-1:0]     exp_req[$];
  logic [DW+1:0]     exp_resp[$];

  arb_txn_mux #(
    .NUM_M(NUM_M), .A_WIDTH(AW), .D_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_we(m_req_we), .m_req_addr(m_req_addr),
    .m_req_wdata(m_req_wdata),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
    .m_resp_rdata(m_resp_rdata), .g_want(g_want),
    .g_req(g_req), .g_resp(g_resp),
    .req_accepted(req_accepted), .resp_accepted(resp_accepted),
    .s_req_valid(s_req_valid), .s_req_we(s_req_we),
    .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
    .s_req_ready(s_req_ready),
    .s_resp_valid(s_resp_valid), .s_resp_rdata(s_resp_rdata),
    .s_resp_ready(s_resp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(int m, logic we, logic [AW-1:0] a,
                       logic [DW-1:0] d, bit push);
    g_req               = GB'(m);
    m_req_valid         = '0;
    m_req_valid[m]      = 1'b1;
    m_req_we[m]         = we;
    m_req_addr[m*AW +: AW]  = a;
    m_req_wdata[m*DW +: DW] = d;
    if (push) exp_req.push_back({we, a, d});
  endtask

  // Request monitor: every subordinate handshake pops one expectation.
  always @(negedge clk) begin
    if (rst_n && s_req_valid && s_req_ready) begin
      if (exp_req.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL s_req_unexpected: got addr %0h expected none",
                 s_req_addr);
      end else begin
        chk("s_req_payload", 64'({s_req_we, s_req_addr, s_req_wdata}),
            64'(exp_req.pop_front()));
      end
    end
  end

  // Response monitor: checks target manager and data on handshake.
  always @(negedge clk) begin
    logic [DW+1:0] e;
    logic [NUM_M-1:0] oh;
    if (resp_accepted) begin
      if (exp_resp.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL resp_unexpected: got %0h expected none",
                 m_resp_rdata);
      end else begin
        e  = exp_resp.pop_front();
        oh = '0;
        oh[e[DW+1:DW]] = 1'b1;
        chk("resp_target", 64'(m_resp_valid), 64'(oh));
        chk("resp_rdata", 64'(m_resp_rdata), 64'(e[DW-1:0]));
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    m_req_valid  = '1;
    m_req_we     = '0;
    m_req_addr   = '0;
    m_req_wdata  = '0;
    m_resp_ready = '0;
    g_req        = GB'(NUM_M);
    g_resp       = GB'(NUM_M);
    s_req_ready  = 1'b0;
    s_resp_valid = 1'b0;
    s_resp_rdata = '0;

    // Reset state with no grants and all managers requesting
    cyc(); cyc();
    mid();
    chk("rst_m_req_ready", 64'(m_req_ready), 64'h0);
    chk("rst_s_req_valid", 64'(s_req_valid), 64'h0);
    chk("rst_req_acc", 64'(req_accepted), 64'h0);
    chk("rst_s_resp_ready", 64'(s_resp_ready), 64'h0);
    chk("rst_s_req_addr", 64'(s_req_addr), 64'h0);
    chk("g_want", 64'(g_want), 64'h3);

    cyc();
    rst_n = 1'b1;
    m_req_valid = '0;
    mid();

    // Out-of-range grant index acts as no grant
    cyc();
    g_req = 2'd3;
    m_req_valid = 2'b11;
    mid();
    chk("oor_m_req_ready", 64'(m_req_ready), 64'h0);
    chk("oor_req_acc", 64'(req_accepted), 64'h0);

    // Single write
    cyc();
    s_req_ready = 1'b1;
    drive(0, 1'b1, 20'h00010, 16'hBEEF, 1);
    mid();
    chk("wr_req_acc", 64'(req_accepted), 64'h1);
    chk("wr_m_req_ready", 64'(m_req_ready), 64'h1);
    chk("wr_s_valid_pre", 64'(s_req_valid), 64'h0);
    cyc();
    m_req_valid = '0;
    mid();
    chk("wr_s_valid", 64'(s_req_valid), 64'h1);
    chk("wr_s_addr", 64'(s_req_addr), 64'h10);
    chk("wr_s_we", 64'(s_req_we), 64'h1);
    cyc();
    mid();
    chk("wr_s_valid_post", 64'(s_req_valid), 64'h0);

    // Backpressure fills the skid, then drains in order
    cyc();
    s_req_ready = 1'b0;
    drive(0, 1'b0, 20'h00001, 16'h1111, 1);
    mid();
    chk("bp_acc1", 64'(req_accepted), 64'h1);
    cyc();
    drive(1, 1'b0, 20'h00002, 16'h2222, 1);
    mid();
    chk("bp_acc2", 64'(req_accepted), 64'h1);
    chk("bp_busy_ready", 64'(m_req_ready), 64'h2);
    cyc();
    m_req_valid = '0;
    mid();
    chk("bp_full_ready", 64'(m_req_ready), 64'h0);
    chk("bp_full_acc", 64'(req_accepted), 64'h0);
    chk("bp_hold_addr1", 64'(s_req_addr), 64'h1);
    chk("bp_hold_valid", 64'(s_req_valid), 64'h1);
    cyc();
    mid();
    chk("bp_hold_addr2", 64'(s_req_addr), 64'h1);
    cyc();
    s_req_ready = 1'b1;
    mid();
    chk("bp_drain_addr1", 64'(s_req_addr), 64'h1);
    cyc();
    mid();
    chk("bp_drain_addr2", 64'(s_req_addr), 64'h2);
    chk("bp_drain_valid", 64'(s_req_valid), 64'h1);
    chk("bp_ready_back", 64'(m_req_ready), 64'h2);
    cyc();
    mid();
    chk("bp_empty", 64'(s_req_valid), 64'h0);

    // Response routing with manager backpressure
    cyc();
    g_resp       = 2'd1;
    s_resp_valid = 1'b1;
    s_resp_rdata = 16'h1234;
    m_resp_ready = 2'b01;
    exp_resp.push_back({2'd1, 16'h1234});
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        cyc();
        m_resp_ready = 2'b11;
      end else if (k == 1) begin
        cyc();
      end
      mid();
      chk("rsp_valid", 64'(m_resp_valid), 64'h2);
      chk("rsp_acc", 64'(resp_accepted), (k == 2) ? 64'h1 : 64'h0);
    end
    chk("rsp_rdata", 64'(m_resp_rdata), 64'h1234);

    // Stray response with no grant is held off
    cyc();
    g_resp       = GB'(NUM_M);
    m_resp_ready = 2'b11;
    s_resp_rdata = 16'h5678;
    mid();
    chk("stray_valid", 64'(m_resp_valid), 64'h0);
    chk("stray_ready", 64'(s_resp_ready), 64'h0);
    chk("stray_acc", 64'(resp_accepted), 64'h0);
    cyc();
    s_resp_valid = 1'b0;
    m_resp_ready = '0;

    // Eight back-to-back requests with simultaneous drain
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      drive(k % 2, k[0], AW'(20'h100 + k), DW'(16'hA000 + k), 1);
      mid();
      chk("b2b_acc", 64'(req_accepted), 64'h1);
      if (k > 0) chk("b2b_s_valid", 64'(s_req_valid), 64'h1);
    end
    cyc();
    m_req_valid = '0;
    mid();
    chk("b2b_last_addr", 64'(s_req_addr), 64'h107);
    cyc();
    mid();
    chk("b2b_done", 64'(s_req_valid), 64'h0);

    // Reset while FULL discards buffered requests
    cyc();
    s_req_ready = 1'b0;
    drive(0, 1'b1, 20'h00003, 16'h3333, 0);
    mid();
    cyc();
    drive(1, 1'b1, 20'h00004, 16'h4444, 0);
    mid();
    cyc();
    m_req_valid = '0;
    mid();
    chk("rf_full_ready", 64'(m_req_ready), 64'h0);
    cyc();
    rst_n = 1'b0;
    mid();
    cyc();
    rst_n = 1'b1;
    s_req_ready = 1'b1;
    mid();
    chk("rf_s_valid", 64'(s_req_valid), 64'h0);
    chk("rf_in_ready", 64'(m_req_ready), 64'h2);
    for (int k = 0; k < 3; k++) begin
      cyc();
      mid();
      chk("rf_no_stale", 64'(s_req_valid), 64'h0);
    end

    chk("req_q_empty", 64'(exp_req.size()), 64'h0);
    chk("resp_q_empty", 64'(exp_resp.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arb_txn_mux.md
# arb_txn_mux

Datapath stage that consumes the request/response grant indices produced by our NUM_M-manager arbiter and moves the actual transactions. It steers the granted manager's request into a registered 2-entry skid buffer driving one subordinate (typically an SRAM controller), and routes the subordinate's in-order responses back to the manager holding the response grant. It generates the arbiter's `g_want`, `req_accepted` and `resp_accepted` inputs, closing the handshake loop.

## Interface
- `NUM_M`, 2: number of managers.
- `A_WIDTH`, 20: request address width.
- `D_WIDTH`, 16: write/read data width.
- `G_BITS` (localparam), $clog2(NUM_M+1): grant index width; value NUM_M means "no grant".

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `m_req_valid`  in  NUM_M  per-manager request valid.
- `m_req_ready`  out  NUM_M  per-manager request ready.
- `m_req_we`  in  NUM_M  per-manager write enable.
- `m_req_addr`  in  NUM_M*A_WIDTH  packed addresses; manager i at [i*A_WIDTH +: A_WIDTH].
- `m_req_wdata`  in  NUM_M*D_WIDTH  packed write data.
- `m_resp_valid`  out  NUM_M  per-manager response valid.
- `m_resp_ready`  in  NUM_M  per-manager response ready.
- `m_resp_rdata`  out  D_WIDTH  response data, broadcast to all managers.
- `g_want`  out  NUM_M  to arbiter; equals `m_req_valid`.
- `g_req`  in  G_BITS  request grant from arbiter.
- `g_resp`  in  G_BITS  response grant from arbiter.
- `req_accepted`  out  1  to arbiter; request handshake completed this cycle.
- `resp_accepted`  out  1  to arbiter; response handshake completed this cycle.
- `s_req_valid`, `s_req_we`, `s_req_addr`, `s_req_wdata`  out  1/1/A_WIDTH/D_WIDTH  registered subordinate request.
- `s_req_ready`  in  1  subordinate request ready.
- `s_resp_valid`  in  1, `s_resp_rdata`  in  D_WIDTH, `s_resp_ready`  out  1: subordinate response.

## Operation
- Every request, read or write, yields exactly one response. The subordinate returns responses in request order.
- Request mux:
  - `in_ready` = !skid_valid (registered).
  - When `g_req < NUM_M`: `m_req_ready[g_req]` = `in_ready`; all other ready bits are 0.
  - When `g_req == NUM_M`: all ready bits are 0.
  - `req_accepted` = `g_req < NUM_M` && `m_req_valid[g_req]` && `in_ready`.
- Skid buffer: output register (out_valid, payload) plus skid register (skid_valid, payload). Payload = {we, addr, wdata}.
  - EMPTY (!out_valid): accept → load out; go to BUSY.
  - BUSY (out_valid, !skid_valid):
    - drain (`s_req_ready`) and accept → load out, stay BUSY.
    - drain only → EMPTY.
    - accept only → load skid, go to FULL.
  - FULL (out_valid, skid_valid): no accept possible. Drain → out <= skid; go to BUSY.
  - `s_req_*` come directly from the out register. The payload holds stable while `s_req_valid && !s_req_ready`.
- Response routing (combinational):
  - When `g_resp < NUM_M`:
    - `m_resp_valid[g_resp]` = `s_resp_valid`; all others 0.
    - `s_resp_ready` = `m_resp_ready[g_resp]`.
  - When `g_resp == NUM_M`: all `m_resp_valid` are 0 and `s_resp_ready` = 0. A stray `s_resp_valid` is held off, never dropped.
  - `resp_accepted` = `s_resp_valid && s_resp_ready`.
  - `m_resp_rdata` = `s_resp_rdata` unconditionally.
- Grant indices ≥ NUM_M are treated as "no grant".

## Timing
- Reset values: EMPTY, out_valid = 0, skid_valid = 0, `s_req_valid` = 0, `s_req_we/addr/wdata` = 0, `in_ready` = 1.
  - Combinational outputs follow their inputs. With `g_req = NUM_M`, all `m_req_ready` are 0 and `req_accepted` = 0.
- Latency:
  - Upstream accept at edge N → `s_req_valid` high after edge N, i.e. 1 cycle.
  - Response path: 0 cycles.
- Throughput: 1 request/cycle while the subordinate is ready. Rate is limited only by the arbiter's grant policy.
- `in_ready` drops the cycle after the skid loads. It rises the cycle after the FULL→BUSY drain.
- The request mux follows `g_req` in the same cycle with no internal latch of the grant. Payload is sampled only at `req_accepted`.
- Same-cycle `req_accepted` and `resp_accepted` are independent and both legal.
- Reset asserted mid-transaction: both registers are cleared at the next edge. Buffered requests are discarded, and no response is owed for them.

## Test plan
- Reset with `g_req = g_resp = NUM_M` and all `m_req_valid = 1` → all readies 0, `s_req_valid = 0`, `req_accepted = 0`, `s_resp_ready = 0`.
- Single write: `g_req = 0`, m0 write addr 0x00010, wdata 0xBEEF, `s_req_ready = 1` → `req_accepted` at edge N; `s_req_valid` with addr 0x00010 and we = 1 at N+1; `s_req_valid` deasserts at N+2.
- Backpressure: `s_req_ready = 0` for 3 cycles while m0 then m1 issue addr 0x1 then 0x2 → FULL after two accepts, `m_req_ready` = 0, `s_req_addr` held at 0x1; on release, 0x1 then 0x2 drain on consecutive cycles.
- Response routing: `g_resp = 1`, `s_resp_valid = 1`, rdata 0x1234, `m_resp_ready[1] = 0` for 2 cycles then 1 → `m_resp_valid = 2'b10` throughout, `resp_accepted` only in the third cycle, `m_resp_valid[0] = 0` always.
- Simultaneous drain and accept in BUSY for 8 back-to-back requests → one `s_req` per cycle, never FULL, addresses in acceptance order.
- Reset during FULL → next cycle `s_req_valid = 0` and `in_ready = 1`; no stale request appears after reset release.
